clock_divider_bank: RTL and testbench

Parametrised bank of independent programmable clock dividers, each deriving a 50 %-duty divided clock and a one-cycle tick strobe from the 50 MHz system clock. Per-channel half-period values are loaded at run time through a valid/ready write port and take effect only at a period boundary, so an output never emits a runt pulse. All channels can be realigned with a common sync strobe. The block feeds display refresh, sampling and animation timing in the visualizer, replacing fixed single-rate dividers.

---
 rtl/clock_divider_pkg.sv | 23 ++
 rtl/clock_divider_channel.sv | 81 ++++++++
 rtl/clock_divider_bank.sv | 54 +++++
 tb/tb_clock_divider_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared defaults and helpers for the programmable clock divider bank.
package clock_divider_pkg;

  localparam int unsigned DEF_N_CH  = 4;
  localparam int unsigned DEF_CNT_W = 19;
  localparam int unsigned DEF_HALF  = 125000;  // 200 Hz from a 50 MHz clock

  // Architectural view of one channel at the default counter width.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] cnt;
    logic [DEF_CNT_W-1:0] half;
    logic [DEF_CNT_W-1:0] shadow;
    logic                 pend;
    logic                 clk;
    logic                 tick;
  } ch_state_t;

  // Width of a channel selector; a single channel still gets one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, shadowed half-period with boundary apply, outputs.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] shadow;
  logic             stopped;
  logic             idle;
  logic             last;

  assign stopped = (half == '0);
  assign idle    = stopped || !en;
  // >= rather than == so a count left above a newly applied half still wraps.
  assign last    = (cnt >= half - CNT_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      half    <= CNT_W'(DEFAULT_HALF);
      shadow  <= '0;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (sync) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      if (wr) begin
        half   <= wr_half;
        shadow <= wr_half;
      end else if (pend) begin
        half <= shadow;
      end
    end else begin
      if (idle) begin
        tick <= 1'b0;
        if (stopped) begin
          cnt     <= '0;
          clk_out <= 1'b0;
        end
        if (pend) begin
          half <= shadow;
          pend <= 1'b0;
        end
      end else if (last) begin
        cnt     <= '0;
        clk_out <= !clk_out;
        tick    <= !clk_out;
        if (clk_out && pend) begin
          half <= shadow;
          pend <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      // The top only grants a write while pend is clear, so this never races the apply.
      if (wr) begin
        shadow <= wr_half;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers with a shared write port and sync.
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter  int unsigned N_CH         = DEF_N_CH,
  parameter  int unsigned CNT_W        = DEF_CNT_W,
  parameter  int unsigned DEFAULT_HALF = DEF_HALF,
  localparam int unsigned CH_W         = sel_width(N_CH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_half,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] sel;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr;

  // An out-of-range channel selects nothing, so it reads ready and is dropped.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sel[i] = (wr_ch == CH_W'(i));
    end
  end

  assign wr_ready = ~|(sel & pend);
  assign wr       = sel & {N_CH{wr_valid & wr_ready}};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clock_divider_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_half (wr_half),
      .pend    (pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench: expected clk_out edges are queued per channel and matched as they occur.
module tb_clock_divider_bank;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 8;

  logic           clock    = 1'b0;
  logic           reset    = 1'b1;
  logic           sync     = 1'b0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [1:0]     wr_ch    = '0;
  logic [CW-1:0]  wr_half  = '0;
  logic [NCH-1:0] en       = 3'b011;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  typedef struct {
    int cyc;
    bit rise;
  } ev_t;

  ev_t  q0[$];
  ev_t  q1[$];
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   t0     = 0;
  int   t1     = 0;
  bit   mon_on = 1'b0;
  logic [1:0] prev = '0;

  clock_divider_bank #(
    .N_CH         (NCH),
    .CNT_W        (CW),
    .DEFAULT_HALF (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_ch    (wr_ch),
    .wr_half  (wr_half),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial forever #10 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc - t0);
    end
  endtask

  task automatic push(input int ch, input int c, input bit r);
    ev_t e;
    e.cyc  = t0 + c;
    e.rise = r;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic push_t1(input int ch, input int c, input bit r);
    ev_t e;
    e.cyc  = t1 + c;
    e.rise = r;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic at(input int c);
    while (cyc < t0 + c) step();
  endtask

  task automatic drive_wr(input logic v, input logic [1:0] c, input logic [CW-1:0] h);
    wr_valid = v;
    wr_ch    = c;
    wr_half  = h;
    #1;
  endtask

  // Edge monitor: every clk_out transition on channels 0/1 must match the queue head.
  initial begin
    ev_t  e;
    logic now;
    logic rose;
    int   n;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        for (int ch = 0; ch < 2; ch++) begin
          now  = clk_out[ch];
          rose = now && !prev[ch];
          if (now !== prev[ch]) begin
            n = (ch == 0) ? q0.size() : q1.size();
            chk($sformatf("ch%0d_edge_expected", ch), 32'(n > 0), 1);
            if (n > 0) begin
              if (ch == 0) e = q0.pop_front();
              else         e = q1.pop_front();
              chk($sformatf("ch%0d_edge_cycle", ch), cyc - t0, e.cyc - t0);
              chk($sformatf("ch%0d_edge_kind", ch), 32'(rose), 32'(e.rise));
            end
          end
          if (rose || tick[ch]) chk($sformatf("ch%0d_tick_on_rise", ch), 32'(tick[ch]), 32'(rose));
        end
      end
      prev = clk_out[1:0];
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);

    mon_on = 1'b1;
    reset  = 1'b0;
    t0     = cyc;
    for (int k = 0; k < 3; k++) begin
      push(0, 4 + 8 * k, 1'b1);
      push(0, 8 + 8 * k, 1'b0);
      push(1, 4 + 8 * k, 1'b1);
      push(1, 8 + 8 * k, 1'b0);
    end

    // Channel 2 is disabled: its pending value applies on the following cycle.
    at(2);  drive_wr(1'b1, 2'd2, 8'd1); chk("ch2_ready_free", 32'(wr_ready), 1);
    at(3);  drive_wr(1'b0, 2'd2, 8'd0); chk("ch2_ready_pend", 32'(wr_ready), 0);
    at(4);  chk("ch2_ready_applied", 32'(wr_ready), 1);
    at(5);  drive_wr(1'b1, 2'd3, 8'd0); chk("oob_ready", 32'(wr_ready), 1);
    at(6);  drive_wr(1'b0, 2'd1, 8'd0); chk("ch1_ready_idle", 32'(wr_ready), 1);

    // Mid-high write to ch0: the running period completes before half=2 takes over.
    at(21); drive_wr(1'b1, 2'd0, 8'd2); chk("ch0_wr1_ready", 32'(wr_ready), 1);
    for (int k = 0; k < 5; k++) begin
      push(0, 26 + 4 * k, 1'b1);
      push(0, 28 + 4 * k, 1'b0);
    end
    at(22); drive_wr(1'b1, 2'd0, 8'd3); chk("ch0_wr2_blocked", 32'(wr_ready), 0);
    at(23); drive_wr(1'b1, 2'd1, 8'd0); chk("ch1_wr_same_window", 32'(wr_ready), 1);
    push(1, 28, 1'b1);
    push(1, 32, 1'b0);
    at(24); drive_wr(1'b0, 2'd0, 8'd0); chk("ch0_ready_after_apply", 32'(wr_ready), 1);

    at(38); chk("ch1_stopped_low", 32'(clk_out[1]), 0);

    at(40); drive_wr(1'b1, 2'd1, 8'd3); chk("ch1_restart_ready", 32'(wr_ready), 1);
    push(1, 45, 1'b1); push(1, 48, 1'b0); push(1, 51, 1'b1); push(1, 54, 1'b0); push(1, 57, 1'b1);
    at(41); drive_wr(1'b1, 2'd0, 8'd4); chk("ch0_half4_ready", 32'(wr_ready), 1);
    push(0, 48, 1'b1); push(0, 52, 1'b0); push(0, 56, 1'b1);
    at(42); drive_wr(1'b0, 2'd0, 8'd0);

    // Sync with a same-cycle write to ch1 (half 6) while both channels are high.
    at(58);
    sync = 1'b1;
    drive_wr(1'b1, 2'd1, 8'd6); chk("sync_wr_ready", 32'(wr_ready), 1);
    push(0, 59, 1'b0); push(0, 63, 1'b1); push(0, 67, 1'b0);
    push(1, 59, 1'b0); push(1, 65, 1'b1); push(1, 71, 1'b0); push(1, 77, 1'b1); push(1, 83, 1'b0);
    at(59);
    sync = 1'b0;
    drive_wr(1'b0, 2'd0, 8'd0); chk("sync_clk_low", 32'(clk_out[1:0]), 0);

    // Five frozen cycles stretch ch0's low phase by exactly five.
    at(69); en = 3'b010;
    push(0, 76, 1'b1); push(0, 80, 1'b0); push(0, 84, 1'b1);
    at(74); en = 3'b011;

    at(85); drive_wr(1'b1, 2'd0, 8'd2); chk("ch0_prereset_ready", 32'(wr_ready), 1);
    at(86); drive_wr(1'b0, 2'd0, 8'd0); chk("ch0_prereset_pend", 32'(wr_ready), 0);
    push(0, 88, 1'b0);
    at(87); reset = 1'b1;
    at(88); reset = 1'b0;
    t1 = cyc;
    chk("ch0_pend_cleared", 32'(wr_ready), 1);
    for (int ch = 0; ch < 2; ch++) begin
      push_t1(ch, 4, 1'b1);  push_t1(ch, 8, 1'b0);  push_t1(ch, 12, 1'b1);
      push_t1(ch, 16, 1'b0); push_t1(ch, 20, 1'b1);
    end

    at(110);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("ch2_disabled_low", 32'(clk_out[2]), 0);
    chk("ch2_no_tick", 32'(tick[2]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
